// File: rtl/vram_glyph_reader_if.sv
// rtl/vram_glyph_reader_if.sv - VGA raster coordinates in, pixel and glyph selector out
interface vram_glyph_reader_if #(
  parameter int SEL_W = 4
);
  logic             Activo;
  logic [10:0]      Fila;
  logic [10:0]      Columna;
  logic             Pixel;
  logic             PixelValido;
  logic [SEL_W-1:0] Selector;

  modport master (
    output Activo, Fila, Columna,
    input  Pixel, PixelValido, Selector
  );

  modport slave (
    input  Activo, Fila, Columna,
    output Pixel, PixelValido, Selector
  );
endinterface

// File: rtl/vram_glyph_reader.sv
// rtl/vram_glyph_reader.sv - scaled glyph-ROM pixel source with debounced/auto glyph select
// ROM_DATA bit ((g*GH + r)*GW + c) is glyph g, row r, column c (column 0 = leftmost).
module vram_glyph_reader #(
  parameter int   NUM_GLYPHS = 16,
  parameter int   GW         = 8,
  parameter int   GH         = 16,
  parameter int   ESC_LOG2   = 4,
  parameter int   X0         = 256,
  parameter int   Y0         = 112,
  parameter logic FONDO      = 1'b0,
  parameter int   DEB_CYCLES = 500000,
  parameter int   AUTO_TICKS = 25000000,
  parameter logic [NUM_GLYPHS*GH*GW-1:0] ROM_DATA = {(NUM_GLYPHS*GH*GW/2){2'b10}}
) (
  input  logic Reloj,
  input  logic Reset,
  input  logic Pulsador,
  input  logic Auto,
  vram_glyph_reader_if.slave vga
);
  localparam int SEL_W  = $clog2(NUM_GLYPHS);
  localparam int ROW_W  = $clog2(GH);
  localparam int COL_W  = $clog2(GW);
  localparam int ADDR_W = $clog2(NUM_GLYPHS*GH*GW);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int AUTO_W = $clog2(AUTO_TICKS + 1);

  localparam logic [11:0] X0_12 = 12'(X0);
  localparam logic [11:0] Y0_12 = 12'(Y0);
  localparam logic [11:0] X1_12 = 12'(X0 + (GW << ESC_LOG2));
  localparam logic [11:0] Y1_12 = 12'(Y0 + (GH << ESC_LOG2));

  logic              sync1, sync2, accepted;
  logic [DEB_W-1:0]  deb_cnt;
  logic [AUTO_W-1:0] auto_cnt;
  logic [SEL_W-1:0]  pending, sel;
  logic              press, tick;

  // Press fires on the cycle the debouncer accepts a new low level.
  assign press = (sync2 != accepted) && (deb_cnt == DEB_W'(DEB_CYCLES - 1)) && !sync2;
  assign tick  = Auto && (auto_cnt == AUTO_W'(AUTO_TICKS - 1));

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      accepted <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      sync1 <= Pulsador;
      sync2 <= sync1;
      if (sync2 == accepted) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        accepted <= sync2;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      auto_cnt <= '0;
      pending  <= '0;
      sel      <= '0;
    end else begin
      if (!Auto || tick) auto_cnt <= '0;
      else               auto_cnt <= auto_cnt + AUTO_W'(1);
      if (press || tick)
        pending <= (pending == SEL_W'(NUM_GLYPHS - 1)) ? '0 : pending + SEL_W'(1);
      // Latch at frame start so a glyph change never tears mid-frame.
      if (vga.Fila == 11'd0 && vga.Columna == 11'd0)
        sel <= pending;
    end
  end

  logic [11:0]      fila12, col12;
  logic             inbox;
  logic [COL_W-1:0] dx_d1;
  logic [ROW_W-1:0] dy_d1;
  logic             act_d1, inbox_d1;
  logic             pix_q, valid_q;
  logic [ADDR_W-1:0] rom_addr;

  assign fila12 = {1'b0, vga.Fila};
  assign col12  = {1'b0, vga.Columna};
  assign inbox  = (col12 >= X0_12) && (col12 < X1_12) && (fila12 >= Y0_12) && (fila12 < Y1_12);
  assign rom_addr = ADDR_W'((int'(sel) * GH + int'(dy_d1)) * GW + int'(dx_d1));

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      dx_d1    <= '0;
      dy_d1    <= '0;
      act_d1   <= 1'b0;
      inbox_d1 <= 1'b0;
      pix_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      // Only the glyph cell index survives; out-of-box offsets are masked by inbox_d1.
      dx_d1    <= COL_W'((col12 - X0_12) >> ESC_LOG2);
      dy_d1    <= ROW_W'((fila12 - Y0_12) >> ESC_LOG2);
      act_d1   <= vga.Activo;
      inbox_d1 <= inbox;
      pix_q    <= !act_d1 ? 1'b0 : (inbox_d1 ? ROM_DATA[rom_addr] : FONDO);
      valid_q  <= act_d1;
    end
  end

  assign vga.Pixel       = pix_q;
  assign vga.PixelValido = valid_q;
  assign vga.Selector    = sel;
endmodule

// File: tb/tb_vram_glyph_reader.sv
// tb/tb_vram_glyph_reader.sv - randomized raster/button/auto stimulus against a behavioural model
module tb_vram_glyph_reader;
  localparam int   NG = 16, GW = 8, GH = 16, ESC = 4, X0 = 256, Y0 = 112;
  localparam int   DEB = 20, AT = 100, TOT = NG*GH*GW;
  localparam logic FONDO = 1'b0;

  function automatic logic rom_bit(int g, int r, int c);
    if (r == 0) return (c == 0) || (c == GW-1);
    return ((g*37 + r*11 + c*5 + g*r + r*c) % 7) < 3;
  endfunction

  function automatic logic [TOT-1:0] build_rom();
    logic [TOT-1:0] v;
    v = '0;
    for (int g = 0; g < NG; g++)
      for (int r = 0; r < GH; r++)
        for (int c = 0; c < GW; c++)
          v[(g*GH + r)*GW + c] = rom_bit(g, r, c);
    return v;
  endfunction

  localparam logic [TOT-1:0] ROM_IMG = build_rom();

  logic Reloj = 1'b0;
  logic Reset, Pulsador, Auto;
  vram_glyph_reader_if #(.SEL_W(4)) vga();

  vram_glyph_reader #(
    .NUM_GLYPHS(NG), .GW(GW), .GH(GH), .ESC_LOG2(ESC), .X0(X0), .Y0(Y0), .FONDO(FONDO),
    .DEB_CYCLES(DEB), .AUTO_TICKS(AT), .ROM_DATA(ROM_IMG)
  ) dut (
    .Reloj(Reloj), .Reset(Reset), .Pulsador(Pulsador), .Auto(Auto), .vga(vga)
  );

  always #5 Reloj = ~Reloj;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  int   exp_sel, exp_pending, auto_edges;
  logic acc_m, exp_pix, exp_vld, p_act;
  int   p_fila, p_col;
  logic hist[$];

  function automatic logic pix_of(logic act, int f, int c, int s);
    if (!act) return 1'b0;
    if (c >= X0 && c < X0 + (GW << ESC) && f >= Y0 && f < Y0 + (GH << ESC))
      return rom_bit(s, (f - Y0) >> ESC, (c - X0) >> ESC);
    return FONDO;
  endfunction

  task automatic model_reset();
    exp_sel = 0; exp_pending = 0; auto_edges = 0;
    acc_m = 1'b1; exp_pix = 1'b0; exp_vld = 1'b0; p_act = 1'b0; p_fila = 0; p_col = 0;
    hist = {};
    repeat (DEB + 2) hist.push_front(1'b1);
  endtask

  // Button accepted when the DEB synchronised samples ending two edges back all differ from the accepted level.
  task automatic model_edge();
    logic press, tick, all_diff;
    if (Reset) begin
      model_reset();
      return;
    end
    press = 1'b0; tick = 1'b0; all_diff = 1'b1;
    hist.push_front(Pulsador);
    void'(hist.pop_back());
    for (int i = 2; i <= DEB + 1; i++) if (hist[i] == acc_m) all_diff = 1'b0;
    if (all_diff) begin
      acc_m = ~acc_m;
      press = (acc_m == 1'b0);
    end
    if (Auto) begin
      auto_edges++;
      tick = (auto_edges % AT) == 0;
    end else begin
      auto_edges = 0;
    end
    exp_pix = pix_of(p_act, p_fila, p_col, exp_sel);
    exp_vld = p_act;
    if (vga.Fila == 0 && vga.Columna == 0) exp_sel = exp_pending;
    if (press || tick) exp_pending = (exp_pending + 1) % NG;
    p_act = vga.Activo; p_fila = int'(vga.Fila); p_col = int'(vga.Columna);
  endtask

  task automatic cycle();
    @(posedge Reloj);
    model_edge();
    #1;
    check("pixel", 32'(vga.Pixel), 32'(exp_pix));
    check("valid", 32'(vga.PixelValido), 32'(exp_vld));
    check("selector", 32'(vga.Selector), 32'(exp_sel));
  endtask

  task automatic drive_rand(input bit allow_fs);
    int r;
    r = $urandom_range(0, 15);
    if (allow_fs && r == 0) begin
      vga.Fila = 11'd0; vga.Columna = 11'd0;
    end else if (r < 12) begin
      vga.Columna = 11'($urandom_range(240, 400));
      vga.Fila    = 11'($urandom_range(100, 380));
    end else begin
      vga.Columna = 11'($urandom_range(1, 1023));
      vga.Fila    = 11'($urandom_range(0, 700));
    end
    vga.Activo = ($urandom_range(0, 7) != 0);
  endtask

  task automatic frame_start();
    vga.Fila = 11'd0; vga.Columna = 11'd0; vga.Activo = 1'b1;
    cycle();
  endtask

  int   ecol[4] = '{255, 256, 383, 384};
  logic eexp[4] = '{FONDO, 1'b1, 1'b1, FONDO};

  initial begin
    Reset = 1'b1; Pulsador = 1'b1; Auto = 1'b0;
    vga.Activo = 1'b0; vga.Fila = 11'd0; vga.Columna = 11'd0;
    model_reset();
    repeat (3) cycle();
    @(negedge Reloj);
    Reset = 1'b0;

    repeat (3000) begin drive_rand(1'b1); cycle(); end

    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        vga.Fila = 11'd112; vga.Columna = 11'(ecol[i]); vga.Activo = 1'b1;
      end else begin
        vga.Fila = 11'd600; vga.Columna = 11'd600;
      end
      cycle();
      if (i >= 1) check("box_edge", 32'(vga.Pixel), 32'(eexp[i-1]));
    end

    Pulsador = 1'b0;
    repeat (DEB + 10) begin drive_rand(1'b0); cycle(); end
    Pulsador = 1'b1;
    repeat (60) begin drive_rand(1'b0); cycle(); end
    check("sel_before_frame", 32'(vga.Selector), 32'd0);
    frame_start();
    check("sel_after_press", 32'(vga.Selector), 32'd1);
    repeat (40) begin drive_rand(1'b0); cycle(); end

    repeat (5) begin
      Pulsador = 1'b0;
      repeat (DEB - 1) begin drive_rand(1'b0); cycle(); end
      Pulsador = 1'b1;
      repeat (10) begin drive_rand(1'b0); cycle(); end
    end
    frame_start();
    check("sel_after_bounce", 32'(vga.Selector), 32'd1);

    Auto = 1'b1;
    for (int j = 1; j <= 1760; j++) begin
      Pulsador = !(j >= 500 - DEB - 1 && j < 505);
      if (j % 100 == 50) frame_start();
      else begin drive_rand(1'b0); cycle(); end
    end
    Auto = 1'b0;
    Pulsador = 1'b1;
    repeat (40) begin drive_rand(1'b0); cycle(); end
    frame_start();
    check("sel_after_auto", 32'(vga.Selector), 32'((1 + 17) % NG));

    repeat (50) begin drive_rand(1'b0); cycle(); end
    @(negedge Reloj);
    #2 Reset = 1'b1;
    #1;
    check("rst_pixel", 32'(vga.Pixel), 32'd0);
    check("rst_valid", 32'(vga.PixelValido), 32'd0);
    check("rst_selector", 32'(vga.Selector), 32'd0);
    model_reset();
    repeat (2) begin drive_rand(1'b0); cycle(); end
    @(negedge Reloj);
    Reset = 1'b0;
    repeat (500) begin drive_rand(1'b1); cycle(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
